// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared opcode and next-PC select definitions for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam logic [1:0] C_PCSRC_SEQ     = 2'b00;
    localparam logic [1:0] C_PCSRC_JUMP    = 2'b01;
    localparam logic [1:0] C_PCSRC_BRANCH  = 2'b10;
    localparam logic [1:0] C_PCSRC_SEQ_ALT = 2'b11;

    localparam logic [5:0] C_OP_HALT = 6'b111111;
    localparam logic [5:0] C_OP_J    = 6'd2;
    localparam logic [5:0] C_OP_JAL  = 6'd3;

    // 32-bit modulo increment, so the top word address wraps to zero.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
// ============================================================================
// Module   : fetch_hold_buffer
// Brief    : Parks one fetched word and its PC+4 while IF/ID is stalled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_hold_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_word,
    input  logic [31:0] i_pcp4,
    output logic [31:0] o_word,
    output logic [31:0] o_pcp4,
    output logic        o_valid
);

    logic [31:0] word_q, word_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            word_d  = i_word;
            pcp4_d  = i_pcp4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= 32'h0000_0000;
            pcp4_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign o_word  = word_q;
    assign o_pcp4  = pcp4_q;
    assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: PC, memory handshake and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  PCsrc,
    input  logic        IFflush,
    input  logic        FIM,
    input  logic        stall,
    input  logic [31:0] branchTarget,
    input  logic [25:0] jumpIndex,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] instrOut,
    output logic [5:0]  opcodeOut,
    output logic [31:0] pcPlus4Out,
    output logic        validOut,
    output logic        halted
);

    localparam logic [1:0] C_ST_FETCH  = 2'd0;
    localparam logic [1:0] C_ST_HOLD   = 2'd1;
    localparam logic [1:0] C_ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        FETCH  = C_ST_FETCH,
        HOLD   = C_ST_HOLD,
        HALTED = C_ST_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic [31:0] drop_addr_q, drop_addr_d;

    logic        w_hb_load, w_hb_clear, w_hb_valid;
    logic [31:0] w_hb_word, w_hb_pcp4;
    logic        w_resp, w_redirect;
    logic [31:0] w_redirect_pc, w_pc_plus4, w_addr;

    // While a redirected request is still outstanding the old address stays on the bus.
    assign w_addr        = drop_q ? drop_addr_q : pc_q;
    assign w_resp        = (state_q == FETCH) && imemValid;
    assign w_redirect    = valid_q && ((PCsrc == C_PCSRC_JUMP) || (PCsrc == C_PCSRC_BRANCH));
    assign w_redirect_pc = (PCsrc == C_PCSRC_JUMP) ? {pcp4_q[31:28], jumpIndex, 2'b00}
                                                   : branchTarget;
    assign w_pc_plus4    = pc_inc(pc_q);

    fetch_hold_buffer u_hold (
        .clk     (Clock),
        .rst     (Reset),
        .i_load  (w_hb_load),
        .i_clear (w_hb_clear),
        .i_word  (imemData),
        .i_pcp4  (w_pc_plus4),
        .o_word  (w_hb_word),
        .o_pcp4  (w_hb_pcp4),
        .o_valid (w_hb_valid)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        drop_d      = drop_q;
        drop_addr_d = drop_addr_q;
        w_hb_load   = 1'b0;
        w_hb_clear  = 1'b0;

        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (FIM) begin
            state_d    = HALTED;
            instr_d    = NOP_WORD;
            valid_d    = 1'b0;
            drop_d     = 1'b0;
            w_hb_clear = 1'b0 | 1'b1;
        end else if (w_redirect || IFflush) begin
            // Anything fetched behind the redirected/flushed instruction is wrong-path.
            state_d    = FETCH;
            valid_d    = 1'b0;
            w_hb_clear = 1'b1;
            if (IFflush) begin
                instr_d = NOP_WORD;
            end
            if (w_resp) begin
                drop_d = 1'b0;
            end else if (w_redirect && (state_q == FETCH)) begin
                drop_d      = 1'b1;
                drop_addr_d = w_addr;
            end
            if (w_redirect) begin
                pc_d = w_redirect_pc;
            end
        end else if (state_q == FETCH) begin
            if (w_resp && drop_q) begin
                drop_d = 1'b0;
            end else if (w_resp && stall) begin
                w_hb_load = 1'b1;
                state_d   = HOLD;
            end else if (w_resp) begin
                instr_d = imemData;
                pcp4_d  = w_pc_plus4;
                valid_d = 1'b1;
                pc_d    = w_pc_plus4;
            end
        end else if (!stall) begin
            instr_d    = w_hb_word;
            pcp4_d     = w_hb_pcp4;
            valid_d    = w_hb_valid;
            pc_d       = w_hb_pcp4;
            w_hb_clear = 1'b1;
            state_d    = FETCH;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_WORD;
            pcp4_q      <= 32'h0000_0000;
            valid_q     <= 1'b0;
            drop_q      <= 1'b0;
            drop_addr_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            drop_q      <= drop_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    assign imemReq    = (state_q == FETCH);
    assign imemAddr   = w_addr;
    assign instrOut   = instr_q;
    assign opcodeOut  = instr_q[31:26];
    assign pcPlus4Out = pcp4_q;
    assign validOut   = valid_q;
    assign halted     = (state_q == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit with a capture scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] C_NOP  = 32'hF0F0_0000;
    localparam logic [31:0] C_JUNK = 32'h1357_9BDF;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  PCsrc = 2'b00;
    logic        IFflush = 1'b0;
    logic        FIM = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic [25:0] jumpIndex = 26'h0;
    logic        imemValid = 1'b0;
    logic [31:0] imemData = 32'h0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] instrOut;
    logic [5:0]  opcodeOut;
    logic [31:0] pcPlus4Out;
    logic        validOut;
    logic        halted;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (C_NOP)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .PCsrc        (PCsrc),
        .IFflush      (IFflush),
        .FIM          (FIM),
        .stall        (stall),
        .branchTarget (branchTarget),
        .jumpIndex    (jumpIndex),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemValid    (imemValid),
        .imemData     (imemData),
        .instrOut     (instrOut),
        .opcodeOut    (opcodeOut),
        .pcPlus4Out   (pcPlus4Out),
        .validOut     (validOut),
        .halted       (halted)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] word, input logic [31:0] pcp4);
        exp_t e;
        e.instr = word;
        e.pcp4  = pcp4;
        sb.push_back(e);
    endtask

    task automatic respond(input logic [31:0] word);
        imemValid = 1'b1;
        imemData  = word;
        tick();
        imemValid = 1'b0;
    endtask

    task automatic check_capture(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, instrOut, e.instr);
            chk({tag, "_pcp4"}, pcPlus4Out, e.pcp4);
            chk({tag, "_valid"}, {31'b0, validOut}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] words [3];
        words[0] = 32'h2001_0001;
        words[1] = 32'h2002_0002;
        words[2] = 32'h2003_0003;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_req",    {31'b0, imemReq},  32'd1);
        chk("rst_addr",   imemAddr,          32'h0);
        chk("rst_instr",  instrOut,          C_NOP);
        chk("rst_pcp4",   pcPlus4Out,        32'h0);
        chk("rst_valid",  {31'b0, validOut}, 32'd0);
        chk("rst_halted", {31'b0, halted},   32'd0);
        Reset = 1'b0;

        // Back-to-back zero-latency fetches
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imemAddr, 32'(i * 4));
            expect_word(words[i], 32'(i * 4 + 4));
            respond(words[i]);
            check_capture("seq");
        end

        // Slow memory: address held, IF/ID unchanged while waiting
        tick();
        tick();
        chk("wait_addr",  imemAddr, 32'h0000_000C);
        chk("wait_req",   {31'b0, imemReq}, 32'd1);
        chk("wait_instr", instrOut, words[2]);
        expect_word(32'h2004_0004, 32'h0000_0010);
        respond(32'h2004_0004);
        check_capture("late");

        // Branch with response in the same cycle: word discarded, fetch at target
        PCsrc = C_PCSRC_BRANCH;
        branchTarget = 32'hFFFF_FFFC;
        respond(C_JUNK);
        PCsrc = C_PCSRC_SEQ;
        chk("br_valid", {31'b0, validOut}, 32'd0);
        chk("br_instr", instrOut, 32'h2004_0004);
        chk("br_addr",  imemAddr, 32'hFFFF_FFFC);

        // Wrap of PC+4 at the top of the address space
        expect_word(32'h2005_0005, 32'h0000_0000);
        respond(32'h2005_0005);
        check_capture("wrap");
        chk("wrap_addr", imemAddr, 32'h0000_0000);

        // Branch with the request outstanding: old address held, late word dropped
        PCsrc = C_PCSRC_BRANCH;
        branchTarget = 32'h1000_0004;
        tick();
        PCsrc = C_PCSRC_SEQ;
        chk("drop_addr_hold", imemAddr, 32'h0000_0000);
        chk("drop_valid",     {31'b0, validOut}, 32'd0);
        respond(C_JUNK);
        chk("drop_instr", instrOut, 32'h2005_0005);
        chk("drop_valid2", {31'b0, validOut}, 32'd0);
        chk("drop_addr_tgt", imemAddr, 32'h1000_0004);

        // Jump target formed from pcPlus4Out upper bits and jumpIndex
        expect_word(32'h0800_0010, 32'h1000_0008);
        respond(32'h0800_0010);
        check_capture("jfetch");
        chk("j_opcode", {26'b0, opcodeOut}, {26'b0, C_OP_J});
        PCsrc = C_PCSRC_JUMP;
        jumpIndex = 26'h000_0010;
        respond(C_JUNK);
        PCsrc = C_PCSRC_SEQ;
        chk("j_addr",  imemAddr, 32'h1000_0040);
        chk("j_valid", {31'b0, validOut}, 32'd0);

        // Taken branch plus flush with the wrong-path word arriving
        expect_word(32'h1000_0003, 32'h1000_0044);
        respond(32'h1000_0003);
        check_capture("beq");
        PCsrc = C_PCSRC_BRANCH;
        IFflush = 1'b1;
        branchTarget = 32'h0000_0100;
        respond(C_JUNK);
        PCsrc = C_PCSRC_SEQ;
        IFflush = 1'b0;
        chk("flush_valid", {31'b0, validOut}, 32'd0);
        chk("flush_instr", instrOut, C_NOP);
        chk("flush_addr",  imemAddr, 32'h0000_0100);
        expect_word(32'h2006_0006, 32'h0000_0104);
        respond(32'h2006_0006);
        check_capture("after_flush");

        // Stall across a response: word parked, no requests, spurious strobe ignored
        stall = 1'b1;
        respond(32'h2007_0007);
        for (int i = 0; i < 2; i++) begin
            chk("hold_req",   {31'b0, imemReq}, 32'd0);
            chk("hold_instr", instrOut, 32'h2006_0006);
            chk("hold_pcp4",  pcPlus4Out, 32'h0000_0104);
            respond(C_JUNK);
        end
        chk("hold_req_last", {31'b0, imemReq}, 32'd0);
        stall = 1'b0;
        expect_word(32'h2007_0007, 32'h0000_0108);
        tick();
        check_capture("unhold");
        chk("unhold_addr", imemAddr, 32'h0000_0108);
        chk("unhold_req",  {31'b0, imemReq}, 32'd1);

        // Halt instruction, then every input except Reset is ignored
        expect_word({C_OP_HALT, 26'h0}, 32'h0000_010C);
        respond({C_OP_HALT, 26'h0});
        check_capture("halt_fetch");
        chk("halt_opcode", {26'b0, opcodeOut}, {26'b0, C_OP_HALT});
        FIM = 1'b1;
        tick();
        chk("halt_flag",  {31'b0, halted},   32'd1);
        chk("halt_req",   {31'b0, imemReq},  32'd0);
        chk("halt_valid", {31'b0, validOut}, 32'd0);
        chk("halt_instr", instrOut, C_NOP);
        for (int i = 0; i < 6; i++) begin
            PCsrc     = 2'($urandom_range(0, 3));
            stall     = 1'($urandom_range(0, 1));
            IFflush   = 1'($urandom_range(0, 1));
            FIM       = 1'($urandom_range(0, 1));
            imemValid = 1'b1;
            imemData  = $urandom;
            tick();
            chk("halted_stays", {31'b0, halted},  32'd1);
            chk("halted_noreq", {31'b0, imemReq}, 32'd0);
        end
        PCsrc = C_PCSRC_SEQ;
        stall = 1'b0;
        IFflush = 1'b0;
        FIM = 1'b0;
        imemValid = 1'b0;

        // Asynchronous reset takes effect without a clock edge
        Reset = 1'b1;
        #1;
        chk("arst_halted", {31'b0, halted},  32'd0);
        chk("arst_req",    {31'b0, imemReq}, 32'd1);
        chk("arst_addr",   imemAddr, 32'h0);
        chk("arst_instr",  instrOut, C_NOP);
        tick();
        Reset = 1'b0;
        expect_word(32'h2008_0008, 32'h0000_0004);
        respond(32'h2008_0008);
        check_capture("post_reset");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, 32'h0000_0000, instruction word presented on a bubble.
REQ-003 Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 PCsrc  in  2  next-PC select from control unit: 00 PC+4, 01 jump, 10 branch, 11 treated as 00.
REQ-006 IFflush  in  1  discard the instruction currently in IF/ID.
REQ-007 FIM  in  1  halt request from control unit.
REQ-008 stall  in  1  hazard stall; freeze PC and IF/ID.
REQ-009 branchTarget  in  32  resolved branch address.
REQ-010 jumpIndex  in  26  J/JAL index field of the instruction in IF/ID.
REQ-011 imemReq  out  1  instruction-memory request.
REQ-012 imemAddr  out  32  instruction-memory word address (byte address, low 2 bits 00).
REQ-013 imemValid  in  1  memory response strobe, 1 cycle, 0..N cycles after request.
REQ-014 imemData  in  32  instruction word, valid when imemValid=1.
REQ-015 instrOut  out  32  IF/ID instruction register.
REQ-016 opcodeOut  out  6  instrOut[31:26], feeds control unit opcode.
REQ-017 pcPlus4Out  out  32  IF/ID PC+4 register.
REQ-018 validOut  out  1  IF/ID holds a real instruction.
REQ-019 halted  out  1  unit is in HALTED state.

Function
REQ-020 FSM states SHALL be FETCH, HOLD, HALTED.
REQ-021 FETCH: imemReq=1 and imemAddr=PC, both held constant until imemValid=1.
REQ-022 FETCH, imemValid=1, stall=0: IF/ID <= {imemData, PC+4}, validOut<=1, PC<=next PC, stay FETCH.
REQ-023 FETCH, imemValid=1, stall=1: word and PC+4 captured in hold buffer, IF/ID unchanged, go HOLD.
REQ-024 HOLD: imemReq=0; when stall=0, hold buffer moves into IF/ID, PC<=next PC, go FETCH.
REQ-025 Next PC: PCsrc=01 -> {pcPlus4Out[31:28], jumpIndex, 2'b00}; 10 -> branchTarget; else PC+4.
REQ-026 PCsrc redirect honored only when validOut=1; PCsrc ignored when validOut=0.
REQ-027 Redirect while a request is outstanding: returning word discarded (drop flag), then request at target.
REQ-028 IFflush=1: next edge instrOut<=NOP_WORD, validOut<=0, hold buffer invalidated, regardless of stall.
REQ-029 PC+4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-030 FIM=1 in any state: go HALTED next edge; imemReq=0, validOut=0, instrOut=NOP_WORD, halted=1.
REQ-031 HALTED is terminal until Reset; all inputs except Reset ignored.
REQ-032 Priority per edge: Reset > FIM > redirect/IFflush > stall > sequential advance.
REQ-033 imemValid while imemReq=0 SHALL be ignored.

Reset
REQ-034 Reset SHALL set PC=RESET_PC, state=FETCH, instrOut=NOP_WORD, pcPlus4Out=0, validOut=0, halted=0, drop flag=0, hold buffer invalid.
REQ-035 Reset mid-request: outstanding response is not captured; first request after release is at RESET_PC.

Structure
REQ-036 PCsrc encodings and opcode constants (HALT=6'b111111, J=2, JAL=3) SHALL live in the shared opcode definitions header.
REQ-037 Hold buffer (32-bit word, 32-bit PC+4, valid) SHALL be one sub-module, fetch_hold_buffer.
REQ-038 State encoding SHALL be a localparam set inside fetch_unit.

Verification
REQ-039 Reset, imemValid same cycle as each request, words A,B,C -> imemAddr 0,4,8; instrOut A,B,C; pcPlus4Out 4,8,12.
REQ-040 IF/ID holds J with jumpIndex=26'h000_0010, pcPlus4Out=32'h1000_0008, PCsrc=01 -> next imemAddr 32'h1000_0040.
REQ-041 BEQ in IF/ID, PCsrc=10, IFflush=1, branchTarget=32'h0000_0100, response in flight -> flight word dropped, validOut=0 one cycle, next fetch at 0x100.
REQ-042 stall=1 across an imemValid pulse for 3 cycles -> IF/ID unchanged, imemReq=0 in HOLD, captured word appears in IF/ID the cycle after stall drops.
REQ-043 opcodeOut=6'b111111 and FIM=1 -> halted=1, imemReq=0 forever; Reset -> fetch resumes at RESET_PC.
REQ-044 PC preset to 32'hFFFF_FFFC, sequential fetch -> next imemAddr 32'h0000_0000.
